// File: rtl/pac_ras_ctrl_pkg.sv
// Shared types and default sizing for the program address controller.
package pac_ras_ctrl_pkg;

  localparam int unsigned PAC_ADDR_W     = 16;
  localparam int unsigned PAC_ISSUE_W    = 4;
  localparam int unsigned PAC_STATE_W    = 8;
  localparam int unsigned PAC_NUM_COND   = 2;
  localparam int unsigned PAC_RAS_DEPTH  = 8;
  localparam int unsigned PAC_WAIT_LIMIT = 15;

  typedef logic [PAC_ADDR_W-1:0]  address_t;
  typedef logic [PAC_ISSUE_W-1:0] issue_no_t;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_WAIT, S_ERR} pac_fsm_t;

  // Select width that stays at least one bit for a single channel.
  function automatic int unsigned sel_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pac_ras_ctrl_if.sv
// Instruction/condition bus between the network stage and the program address controller.
interface pac_ras_ctrl_if
  import pac_ras_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W   = PAC_ADDR_W,
  parameter int unsigned ISSUE_W  = PAC_ISSUE_W,
  parameter int unsigned STATE_W  = PAC_STATE_W,
  parameter int unsigned NUM_COND = PAC_NUM_COND
);
  localparam int unsigned SEL_W  = sel_width(NUM_COND);
  localparam int unsigned COND_W = $clog2(STATE_W);

  logic                I_Start;
  logic [ADDR_W-1:0]   I_Start_Addr;
  logic                I_Req;
  logic                I_Stall;
  logic [SEL_W-1:0]    I_Sel_CondValid;
  logic [NUM_COND-1:0] I_CondValid;
  logic                I_Jump;
  logic                I_Call;
  logic                I_Return;
  logic                I_Branch;
  logic [ISSUE_W-1:0]  I_Timing_MY;
  logic [ISSUE_W-1:0]  I_Timing_WB;
  logic [STATE_W-1:0]  I_State;
  logic [COND_W-1:0]   I_Cond;
  logic [ADDR_W-1:0]   I_Src;
  logic                O_IFetch;
  logic [ADDR_W-1:0]   O_Address;
  logic                O_StallReq;
  logic                O_StackFull;
  logic                O_StackEmpty;
  logic                O_Error;

  modport master (
    output I_Start, I_Start_Addr, I_Req, I_Stall, I_Sel_CondValid, I_CondValid,
           I_Jump, I_Call, I_Return, I_Branch, I_Timing_MY, I_Timing_WB,
           I_State, I_Cond, I_Src,
    input  O_IFetch, O_Address, O_StallReq, O_StackFull, O_StackEmpty, O_Error
  );

  modport slave (
    input  I_Start, I_Start_Addr, I_Req, I_Stall, I_Sel_CondValid, I_CondValid,
           I_Jump, I_Call, I_Return, I_Branch, I_Timing_MY, I_Timing_WB,
           I_State, I_Cond, I_Src,
    output O_IFetch, O_Address, O_StallReq, O_StackFull, O_StackEmpty, O_Error
  );

endinterface

// File: rtl/pac_ras_ctrl_ras.sv
// Return-address stack: register array indexed by the entry count, flush has priority.
module pac_ras_ctrl_ras #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned W     = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] top,
  output logic         full,
  output logic         empty
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [W-1:0]     mem [DEPTH];
  logic [CNT_W-1:0] count;

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);
  assign top   = mem[PTR_W'(count - CNT_W'(1))];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (flush) begin
      count <= '0;
    end else if (push && !full) begin
      count <= count + CNT_W'(1);
    end else if (pop && !empty) begin
      count <= count - CNT_W'(1);
    end
  end

  // Storage needs no reset: entries above the count are never read.
  always_ff @(posedge clk) begin
    if (push && !full && !flush) begin
      mem[PTR_W'(count)] <= din;
    end
  end

endmodule

// File: rtl/pac_ras_ctrl.sv
// Program address controller: owns the PC, handles jump/call/return/branch and condition waits.
module pac_ras_ctrl
  import pac_ras_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W     = PAC_ADDR_W,
  parameter int unsigned ISSUE_W    = PAC_ISSUE_W,
  parameter int unsigned STATE_W    = PAC_STATE_W,
  parameter int unsigned NUM_COND   = PAC_NUM_COND,
  parameter int unsigned RAS_DEPTH  = PAC_RAS_DEPTH,
  parameter int unsigned WAIT_LIMIT = PAC_WAIT_LIMIT
) (
  input  logic          clock,
  input  logic          reset,
  pac_ras_ctrl_if.slave bus
);
  localparam int unsigned WCNT_W = $clog2(WAIT_LIMIT + 1);

  pac_fsm_t          state;
  logic [ADDR_W-1:0] pc;
  logic              cond_latch;
  logic [WCNT_W-1:0] wait_cnt;
  logic              ifetch;
  logic              error;

  logic              accept;
  logic              sel_cv;
  logic              timing_ok;
  logic              cond_avail;
  logic              taken;
  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] pc_br;
  logic              push;
  logic              pop;
  logic [ADDR_W-1:0] ras_top;
  logic              ras_full;
  logic              ras_empty;

  // Opcode decode and branch evaluation shared by the FSM and the stack.
  always_comb begin
    accept     = (state == S_RUN) && bus.I_Req && !bus.I_Stall;
    sel_cv     = bus.I_CondValid[bus.I_Sel_CondValid];
    timing_ok  = (bus.I_Timing_MY == ISSUE_W'(bus.I_Timing_WB + ISSUE_W'(1)));
    cond_avail = cond_latch || sel_cv;
    taken      = bus.I_State[bus.I_Cond];
    pc_inc     = pc + ADDR_W'(1);
    pc_br      = pc + bus.I_Src;
    push       = !bus.I_Start && accept && !bus.I_Jump && bus.I_Call && !ras_full;
    pop        = !bus.I_Start && accept && !bus.I_Jump && !bus.I_Call &&
                 bus.I_Return && !ras_empty;
  end

  pac_ras_ctrl_ras #(
    .DEPTH (RAS_DEPTH),
    .W     (ADDR_W)
  ) u_ras (
    .clk   (clock),
    .rst_n (reset),
    .flush (bus.I_Start),
    .push  (push),
    .pop   (pop),
    .din   (pc_inc),
    .top   (ras_top),
    .full  (ras_full),
    .empty (ras_empty)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      pc         <= '0;
      cond_latch <= 1'b0;
      wait_cnt   <= '0;
      ifetch     <= 1'b0;
      error      <= 1'b0;
    end else begin
      ifetch <= 1'b0;
      if (bus.I_Start) begin
        state      <= S_RUN;
        pc         <= bus.I_Start_Addr;
        cond_latch <= 1'b0;
        wait_cnt   <= '0;
        error      <= 1'b0;
        ifetch     <= 1'b1;
      end else begin
        case (state)
          S_RUN: begin
            if (sel_cv) cond_latch <= 1'b1;
            if (accept) begin
              if (bus.I_Jump) begin
                pc     <= bus.I_Src;
                ifetch <= 1'b1;
              end else if (bus.I_Call) begin
                if (ras_full) begin
                  state <= S_ERR;
                  error <= 1'b1;
                end else begin
                  pc     <= bus.I_Src;
                  ifetch <= 1'b1;
                end
              end else if (bus.I_Return) begin
                if (ras_empty) begin
                  state <= S_ERR;
                  error <= 1'b1;
                end else begin
                  pc     <= ras_top;
                  ifetch <= 1'b1;
                end
              end else if (bus.I_Branch) begin
                if (!timing_ok) begin
                  pc     <= pc_inc;
                  ifetch <= 1'b1;
                end else if (cond_avail) begin
                  pc         <= taken ? pc_br : pc_inc;
                  cond_latch <= 1'b0;
                  ifetch     <= 1'b1;
                end else begin
                  state    <= S_WAIT;
                  wait_cnt <= '0;
                end
              end else begin
                pc     <= pc_inc;
                ifetch <= 1'b1;
              end
            end
          end
          // Upstream holds the branch operands stable while we wait here.
          S_WAIT: begin
            if (sel_cv) begin
              pc     <= taken ? pc_br : pc_inc;
              ifetch <= 1'b1;
              state  <= S_RUN;
            end else if (wait_cnt == WCNT_W'(WAIT_LIMIT - 1)) begin
              state <= S_ERR;
              error <= 1'b1;
            end else begin
              wait_cnt <= wait_cnt + WCNT_W'(1);
            end
          end
          S_IDLE, S_ERR: ;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.O_IFetch     = ifetch;
  assign bus.O_Address    = pc;
  assign bus.O_Error      = error;
  assign bus.O_StallReq   = (state == S_WAIT) && !sel_cv;
  assign bus.O_StackFull  = ras_full;
  assign bus.O_StackEmpty = ras_empty;

endmodule

// File: tb/tb_pac_ras_ctrl.sv
// Directed self-checking bench for pac_ras_ctrl.
module tb_pac_ras_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  int unsigned total  = 0;
  int unsigned passed = 0;

  pac_ras_ctrl_if #(.ADDR_W(16), .ISSUE_W(4), .STATE_W(8), .NUM_COND(2)) bus ();

  pac_ras_ctrl #(
    .ADDR_W(16), .ISSUE_W(4), .STATE_W(8), .NUM_COND(2), .RAS_DEPTH(8), .WAIT_LIMIT(15)
  ) dut (
    .clock (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.I_Start = 1'b0; bus.I_Start_Addr = 16'h0; bus.I_Req = 1'b0; bus.I_Stall = 1'b0;
    bus.I_Sel_CondValid = 1'b0; bus.I_CondValid = 2'b00; bus.I_Jump = 1'b0;
    bus.I_Call = 1'b0; bus.I_Return = 1'b0; bus.I_Branch = 1'b0;
    bus.I_Timing_MY = 4'h0; bus.I_Timing_WB = 4'h0; bus.I_State = 8'h00;
    bus.I_Cond = 3'd0; bus.I_Src = 16'h0;
  endtask

  task automatic start_at(input logic [15:0] addr);
    bus.I_Start = 1'b1; bus.I_Start_Addr = addr;
    step();
    bus.I_Start = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 1'b0;
    #2;
    total++; if (bus.O_IFetch !== 1'b0) $display("FAIL rst_ifetch: got %b expected 0", bus.O_IFetch); else passed++;
    total++; if (bus.O_Address !== 16'h0000) $display("FAIL rst_addr: got %h expected 0000", bus.O_Address); else passed++;
    total++; if (bus.O_StallReq !== 1'b0) $display("FAIL rst_stall: got %b expected 0", bus.O_StallReq); else passed++;
    total++; if (bus.O_Error !== 1'b0) $display("FAIL rst_error: got %b expected 0", bus.O_Error); else passed++;
    total++; if (bus.O_StackFull !== 1'b0) $display("FAIL rst_full: got %b expected 0", bus.O_StackFull); else passed++;
    total++; if (bus.O_StackEmpty !== 1'b1) $display("FAIL rst_empty: got %b expected 1", bus.O_StackEmpty); else passed++;
    repeat (2) step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_sequential();
    start_at(16'h0100);
    total++; if (bus.O_Address !== 16'h0100) $display("FAIL seq_start_addr: got %h expected 0100", bus.O_Address); else passed++;
    total++; if (bus.O_IFetch !== 1'b1) $display("FAIL seq_start_ifetch: got %b expected 1", bus.O_IFetch); else passed++;
    bus.I_Req = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      step();
      total++; if (bus.O_Address !== 16'(16'h0100 + i)) $display("FAIL seq_addr%0d: got %h expected %h", i, bus.O_Address, 16'(16'h0100 + i)); else passed++;
      total++; if (bus.O_IFetch !== 1'b1) $display("FAIL seq_ifetch%0d: got %b expected 1", i, bus.O_IFetch); else passed++;
    end
    bus.I_Req = 1'b0;
    step();
    total++; if (bus.O_IFetch !== 1'b0) $display("FAIL seq_hold_ifetch: got %b expected 0", bus.O_IFetch); else passed++;
    total++; if (bus.O_Address !== 16'h0103) $display("FAIL seq_hold_addr: got %h expected 0103", bus.O_Address); else passed++;
  endtask

  task automatic test_call_return();
    start_at(16'h0010);
    total++; if (bus.O_StackEmpty !== 1'b1) $display("FAIL cr_empty0: got %b expected 1", bus.O_StackEmpty); else passed++;
    bus.I_Req = 1'b1; bus.I_Call = 1'b1; bus.I_Src = 16'h0200;
    step();
    total++; if (bus.O_Address !== 16'h0200) $display("FAIL cr_call_addr: got %h expected 0200", bus.O_Address); else passed++;
    total++; if (bus.O_StackEmpty !== 1'b0) $display("FAIL cr_empty1: got %b expected 0", bus.O_StackEmpty); else passed++;
    bus.I_Call = 1'b0; bus.I_Return = 1'b1;
    step();
    total++; if (bus.O_Address !== 16'h0011) $display("FAIL cr_ret_addr: got %h expected 0011", bus.O_Address); else passed++;
    total++; if (bus.O_StackEmpty !== 1'b1) $display("FAIL cr_empty2: got %b expected 1", bus.O_StackEmpty); else passed++;
    bus.I_Call = 1'b1; bus.I_Src = 16'h0300;
    step();
    total++; if (bus.O_Address !== 16'h0300) $display("FAIL cr_both_addr: got %h expected 0300", bus.O_Address); else passed++;
    total++; if (bus.O_StackEmpty !== 1'b0) $display("FAIL cr_both_empty: got %b expected 0", bus.O_StackEmpty); else passed++;
    bus.I_Call = 1'b0;
    step();
    total++; if (bus.O_Address !== 16'h0012) $display("FAIL cr_ret2_addr: got %h expected 0012", bus.O_Address); else passed++;
    step();
    total++; if (bus.O_Error !== 1'b1) $display("FAIL cr_underflow_err: got %b expected 1", bus.O_Error); else passed++;
    total++; if (bus.O_Address !== 16'h0012) $display("FAIL cr_underflow_addr: got %h expected 0012", bus.O_Address); else passed++;
    total++; if (bus.O_IFetch !== 1'b0) $display("FAIL cr_underflow_ifetch: got %b expected 0", bus.O_IFetch); else passed++;
    clear_inputs();
  endtask

  task automatic test_ras_overflow();
    start_at(16'h0000);
    bus.I_Req = 1'b1; bus.I_Call = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.I_Src = 16'(16'h1000 + 16 * i);
      step();
    end
    total++; if (bus.O_StackFull !== 1'b1) $display("FAIL ovf_full: got %b expected 1", bus.O_StackFull); else passed++;
    total++; if (bus.O_Address !== 16'h1070) $display("FAIL ovf_8th_addr: got %h expected 1070", bus.O_Address); else passed++;
    total++; if (bus.O_Error !== 1'b0) $display("FAIL ovf_pre_err: got %b expected 0", bus.O_Error); else passed++;
    bus.I_Src = 16'h2000;
    step();
    total++; if (bus.O_Error !== 1'b1) $display("FAIL ovf_err: got %b expected 1", bus.O_Error); else passed++;
    total++; if (bus.O_Address !== 16'h1070) $display("FAIL ovf_addr_held: got %h expected 1070", bus.O_Address); else passed++;
    total++; if (bus.O_IFetch !== 1'b0) $display("FAIL ovf_ifetch: got %b expected 0", bus.O_IFetch); else passed++;
    step();
    total++; if (bus.O_Error !== 1'b1) $display("FAIL ovf_err_sticky: got %b expected 1", bus.O_Error); else passed++;
    clear_inputs();
    start_at(16'h0040);
    total++; if (bus.O_Error !== 1'b0) $display("FAIL ovf_start_err: got %b expected 0", bus.O_Error); else passed++;
    total++; if (bus.O_StackEmpty !== 1'b1) $display("FAIL ovf_start_empty: got %b expected 1", bus.O_StackEmpty); else passed++;
    total++; if (bus.O_Address !== 16'h0040) $display("FAIL ovf_start_addr: got %h expected 0040", bus.O_Address); else passed++;
  endtask

  task automatic test_branch_wait();
    start_at(16'h0020);
    bus.I_Req = 1'b1; bus.I_Branch = 1'b1; bus.I_Timing_MY = 4'h5; bus.I_Timing_WB = 4'h4;
    bus.I_State = 8'h04; bus.I_Cond = 3'd2; bus.I_Src = 16'hFFFC; bus.I_Sel_CondValid = 1'b1;
    step();
    total++; if (bus.O_StallReq !== 1'b1) $display("FAIL bw_stall1: got %b expected 1", bus.O_StallReq); else passed++;
    total++; if (bus.O_Address !== 16'h0020) $display("FAIL bw_addr_held: got %h expected 0020", bus.O_Address); else passed++;
    total++; if (bus.O_IFetch !== 1'b0) $display("FAIL bw_ifetch_wait: got %b expected 0", bus.O_IFetch); else passed++;
    bus.I_CondValid = 2'b01;
    #1;
    total++; if (bus.O_StallReq !== 1'b1) $display("FAIL bw_wrong_channel: got %b expected 1", bus.O_StallReq); else passed++;
    step();
    bus.I_CondValid = 2'b00;
    total++; if (bus.O_StallReq !== 1'b1) $display("FAIL bw_stall2: got %b expected 1", bus.O_StallReq); else passed++;
    step();
    total++; if (bus.O_StallReq !== 1'b1) $display("FAIL bw_stall3: got %b expected 1", bus.O_StallReq); else passed++;
    bus.I_CondValid = 2'b10;
    #1;
    total++; if (bus.O_StallReq !== 1'b0) $display("FAIL bw_stall_drop: got %b expected 0", bus.O_StallReq); else passed++;
    step();
    clear_inputs();
    total++; if (bus.O_Address !== 16'h001C) $display("FAIL bw_taken_addr: got %h expected 001c", bus.O_Address); else passed++;
    total++; if (bus.O_IFetch !== 1'b1) $display("FAIL bw_ifetch: got %b expected 1", bus.O_IFetch); else passed++;
  endtask

  task automatic test_branch_latch_wrap();
    start_at(16'h0030);
    bus.I_Sel_CondValid = 1'b0; bus.I_CondValid = 2'b01;
    step();
    bus.I_CondValid = 2'b00;
    bus.I_Req = 1'b1; bus.I_Branch = 1'b1; bus.I_Timing_MY = 4'h0; bus.I_Timing_WB = 4'hF;
    bus.I_State = 8'hFB; bus.I_Cond = 3'd2; bus.I_Src = 16'h0008;
    #1;
    total++; if (bus.O_StallReq !== 1'b0) $display("FAIL bl_no_stall: got %b expected 0", bus.O_StallReq); else passed++;
    step();
    total++; if (bus.O_Address !== 16'h0031) $display("FAIL bl_not_taken: got %h expected 0031", bus.O_Address); else passed++;
    total++; if (bus.O_StallReq !== 1'b0) $display("FAIL bl_stall_after: got %b expected 0", bus.O_StallReq); else passed++;
    step();
    total++; if (bus.O_StallReq !== 1'b1) $display("FAIL bl_latch_consumed: got %b expected 1", bus.O_StallReq); else passed++;
    total++; if (bus.O_Address !== 16'h0031) $display("FAIL bl_wait_addr: got %h expected 0031", bus.O_Address); else passed++;
    bus.I_State = 8'h04; bus.I_CondValid = 2'b01;
    step();
    bus.I_CondValid = 2'b00;
    total++; if (bus.O_Address !== 16'h0039) $display("FAIL bl_taken_addr: got %h expected 0039", bus.O_Address); else passed++;
    bus.I_Timing_MY = 4'h3; bus.I_Timing_WB = 4'h3;
    step();
    total++; if (bus.O_Address !== 16'h003A) $display("FAIL bl_bad_timing_addr: got %h expected 003a", bus.O_Address); else passed++;
    total++; if (bus.O_StallReq !== 1'b0) $display("FAIL bl_bad_timing_stall: got %b expected 0", bus.O_StallReq); else passed++;
    clear_inputs();
  endtask

  task automatic test_wait_timeout();
    start_at(16'h0050);
    bus.I_Req = 1'b1; bus.I_Branch = 1'b1; bus.I_Timing_MY = 4'h1; bus.I_Timing_WB = 4'h0;
    bus.I_Sel_CondValid = 1'b1; bus.I_Src = 16'h0004;
    step();
    repeat (14) step();
    total++; if (bus.O_StallReq !== 1'b1) $display("FAIL to_last_wait_stall: got %b expected 1", bus.O_StallReq); else passed++;
    total++; if (bus.O_Error !== 1'b0) $display("FAIL to_early_err: got %b expected 0", bus.O_Error); else passed++;
    step();
    total++; if (bus.O_Error !== 1'b1) $display("FAIL to_err: got %b expected 1", bus.O_Error); else passed++;
    total++; if (bus.O_StallReq !== 1'b0) $display("FAIL to_stall_in_err: got %b expected 0", bus.O_StallReq); else passed++;
    total++; if (bus.O_Address !== 16'h0050) $display("FAIL to_addr: got %h expected 0050", bus.O_Address); else passed++;
    clear_inputs();
  endtask

  task automatic test_pc_wrap();
    start_at(16'hFFFF);
    total++; if (bus.O_Error !== 1'b0) $display("FAIL wrap_err_clear: got %b expected 0", bus.O_Error); else passed++;
    bus.I_Req = 1'b1;
    step();
    total++; if (bus.O_Address !== 16'h0000) $display("FAIL wrap_addr: got %h expected 0000", bus.O_Address); else passed++;
    total++; if (bus.O_IFetch !== 1'b1) $display("FAIL wrap_ifetch: got %b expected 1", bus.O_IFetch); else passed++;
    clear_inputs();
  endtask

  task automatic test_reset_mid_wait();
    start_at(16'h0060);
    bus.I_Req = 1'b1; bus.I_Branch = 1'b1; bus.I_Timing_MY = 4'h8; bus.I_Timing_WB = 4'h7;
    bus.I_Sel_CondValid = 1'b1;
    step();
    total++; if (bus.O_StallReq !== 1'b1) $display("FAIL rw_stall: got %b expected 1", bus.O_StallReq); else passed++;
    #2 rst_n = 1'b0;
    #1;
    total++; if (bus.O_Address !== 16'h0000) $display("FAIL rw_addr: got %h expected 0000", bus.O_Address); else passed++;
    total++; if (bus.O_StallReq !== 1'b0) $display("FAIL rw_stall_cleared: got %b expected 0", bus.O_StallReq); else passed++;
    #2 rst_n = 1'b1;
    bus.I_Branch = 1'b0;
    step();
    total++; if (bus.O_Address !== 16'h0000) $display("FAIL rw_idle_addr: got %h expected 0000", bus.O_Address); else passed++;
    total++; if (bus.O_IFetch !== 1'b0) $display("FAIL rw_idle_ifetch: got %b expected 0", bus.O_IFetch); else passed++;
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_call_return();
    test_ras_overflow();
    test_branch_wait();
    test_branch_latch_wrap();
    test_wait_timeout();
    test_pc_wrap();
    test_reset_mid_wait();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
